cpu_io_bridge: RTL

CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

---
 rtl/cpu_io_bridge_pkg.sv | 13 +
 rtl/io_sync_fifo.sv | 58 +++++
 rtl/cpu_io_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_io_bridge_pkg.sv
// Shared constants and input-path FSM encoding for cpu_io_bridge.
package cpu_io_bridge_pkg;

  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned DEFAULT_DEPTH       = 4;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } in_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is 0 while empty.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
  end

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are unobservable after reset because pointers clear
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cpu_io_bridge.sv
// Host <-> CPU port bridge: held input write path plus change-capture FIFO.
// Optional feature macro: CPU_IO_BRIDGE_DROP_CNT_EN adds a saturating drop_cnt output.
module cpu_io_bridge
  import cpu_io_bridge_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [BYTE_W-1:0] cpu_in,
  input  logic [BYTE_W-1:0] cpu_out,
  output logic [BYTE_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              overflow
`ifdef CPU_IO_BRIDGE_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  in_state_e         state_q, state_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [BYTE_W-1:0] cpu_in_q, cpu_in_d;
  logic [BYTE_W-1:0] last_out_q, last_out_d;
  logic              overflow_q, overflow_d;
  logic              change, push, pop, drop;
  logic              fifo_full, fifo_empty;

  // State register for the input path, output sampler and sticky flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      cpu_in_q   <= '0;
      last_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cpu_in_q   <= cpu_in_d;
      last_out_q <= last_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state: accept in idle, then count down the hold window
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cpu_in_d   = cpu_in_q;
    unique case (state_q)
      StIdle: begin
        if (host_in_valid) begin
          state_d    = StHold;
          hold_cnt_d = HoldLast;
          cpu_in_d   = host_in_data;
        end
      end
      StHold: begin
        if (hold_cnt_q == '0) state_d = StIdle;
        else                  hold_cnt_d = hold_cnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs of the input path; ready is masked while reset is high
  always_comb begin
    host_in_ready = (state_q == StIdle) & ~rst;
    cpu_in        = cpu_in_q;
  end

  // Change detection and drop accounting on the capture side
  always_comb begin
    last_out_d = cpu_out;
    change     = (cpu_out != last_out_q);
    push       = change & ~rst;
    pop        = host_out_ready & ~rst;
    // Full implies non-empty, so a pop here always frees a slot.
    drop       = push & fifo_full & ~pop;
    overflow_d = overflow_q | drop;
  end

  io_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cpu_out),
    .rdata_o (host_out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign host_out_valid = ~fifo_empty;
  assign overflow       = overflow_q;

`ifdef CPU_IO_BRIDGE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped bytes
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Drop counting disabled: only the sticky overflow flag reports drops.
`endif

endmodule
